tokenizer_stream: RTL and testbench
===================================

Name: tokenizer_stream

Overview:
Byte-serial tokenizer, successor to the fixed-size line-buffer tokenizer in the compiler front end.
- Takes UART bytes over a valid/ready handshake and splits them into tokens on configurable delimiters.
- Buffers characters in a parametrised circular FIFO and releases only complete tokens to the parser, framed with first/last/EOL/truncation flags.
- Sits between the UART receiver and the parser; provides real back-pressure instead of assuming the parser keeps up.

Parameters:
- DATA_WIDTH, 8: character width in bits.
- DEPTH, 64: FIFO entries; power of two; must be > MAX_TOKEN.
- MAX_TOKEN, 32: maximum stored characters per token; must be ≥ 1.
- EOL, "\n": line terminator; is also emitted as its own one-character token.
- WC, " ": word separator.
- WC2, "\t": second word separator.

Ports:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_en, input, 1: block enable; when low, both handshakes are stalled and all state is held.
- i_data, input, DATA_WIDTH: input character.
- i_valid, input, 1: input character valid.
- o_ready, output, 1: block can accept the input character.
- o_data, output, DATA_WIDTH: output character.
- o_valid, output, 1: output character valid.
- i_ready, input, 1: parser accepts the output character.
- o_first, output, 1: current output character is the first of its token.
- o_last, output, 1: current output character is the last of its token.
- o_eol, output, 1: current output is the EOL token (o_last=1 and o_data==EOL).
- o_trunc, output, 1: on the last character only; token exceeded MAX_TOKEN and was truncated.
- o_tokens, output, $clog2(DEPTH)+1: number of complete tokens held in the FIFO.

Behaviour:
- Reset (i_rst_n=0, immediate): o_valid=0, o_ready=0, o_first=0, o_last=0, o_eol=0, o_trunc=0, o_tokens=0. Pointers, staging register, length counter and eol_pending are all cleared. A partial token is discarded. Reset mid-token loses that token with no flag.
- Input accept: a character is accepted when i_en && i_valid && o_ready.
- o_ready = i_en && !fifo_full && !eol_pending. This is registered-state-derived, with no combinational path from i_valid.
- Staging register holds the latest non-delimiter character of the open token, together with its first and trunc bits.
- Accepted character is a non-delimiter:
  - If staging is valid, push staging to the FIFO with last=0.
  - Load the new character into staging; first=1 if no token is open.
  - Length counter +1.
  - If the length counter is already at MAX_TOKEN, drop the character, set the staging trunc bit, and leave staging unchanged.
- Accepted WC or WC2:
  - If staging is valid, push it with last=1 and close the token.
  - Otherwise no action; runs of separators are collapsed.
- Accepted EOL:
  - If staging is valid, push it with last=1.
  - Set eol_pending. On the next enabled cycle, push an entry {EOL, first=1, last=1} and clear eol_pending.
  - An EOL with no open token pushes only the EOL entry (one cycle earlier).
- A push with last=1 increments the token count.
- Output:
  - o_valid = i_en && (token count != 0).
  - o_data and flags are read combinationally from the FIFO head.
  - A pop occurs on o_valid && i_ready. A pop with last=1 decrements the token count.
  - Push-last and pop-last in the same cycle leave the count unchanged.
- Latency: the terminating entry is written on edge N; o_valid rises after edge N. Characters of an open token are never visible at the output.
- Full FIFO: o_ready drops and the input stalls. Because DEPTH > MAX_TOKEN, a complete token always exists when the FIFO is full, so there is no deadlock.
- Pointer wrap is modulo DEPTH; full/empty is resolved with an extra pointer MSB.

Optional Feature:
- TOKENIZER_CASEFOLD_EN defined: ASCII 'a'..'z' are folded to 'A'..'Z' before storing. Delimiter comparison uses the unfolded byte.
- Undefined: characters are stored verbatim.

Decomposition:
- tokenizer_pkg: entry struct {data, first, last, trunc}; character constants (EOL, WC, WC2, case-fold offset); is_delim function.
- Sub-module tokenizer_fifo: single-clock FIFO with asynchronous read, parametrised DEPTH and entry width, with full/empty/level outputs. Staging, token counting and flag logic stay in tokenizer_stream.

Test Plan:
- "AB CD\n" with i_ready=1 → outputs A(f) B(l), C(f) D(l), \n(f,l,eol); o_tokens peaks at 2; o_trunc=0 throughout.
- "  X\t\t\n" → X(f,l) then \n(f,l,eol); no empty tokens are produced.
- MAX_TOKEN=4, input "ABCDEFG " → A B C D with D(l,trunc); E F G are dropped.
- DEPTH=8, MAX_TOKEN=4, i_ready=0, input "AB CD EF GH IJ" → o_ready drops once 8 entries are stored; raising i_ready drains AB and then resumes input acceptance.
- Assert i_rst_n low mid-token "AB" → all outputs 0 immediately; after release, "Q " → Q(f,l) only.
- TOKENIZER_CASEFOLD_EN defined, input "dup " → D U P; without the macro → d u p.

Source files
------------

// File: rtl/tokenizer_pkg.sv
// tokenizer_pkg
// Shared definitions for the byte-serial tokenizer:
//   - default character constants (EOL, word separators, case-fold range/offset)
//   - input character classification enum
//   - per-entry flag struct {first, last, trunc}
//   - is_delim / classify helpers
// The optional build macro TOKENIZER_CASEFOLD_EN is consumed by tokenizer_stream.
package tokenizer_pkg;

  localparam logic [7:0] TOK_CHAR_EOL     = 8'h0A;
  localparam logic [7:0] TOK_CHAR_WC      = 8'h20;
  localparam logic [7:0] TOK_CHAR_WC2     = 8'h09;
  localparam logic [7:0] TOK_CHAR_LOWER_A = 8'h61;
  localparam logic [7:0] TOK_CHAR_LOWER_Z = 8'h7A;
  localparam logic [7:0] TOK_FOLD_OFFSET  = 8'h20;

  typedef enum logic [1:0] {
    CLS_CHAR = 2'd0,
    CLS_SEP  = 2'd1,
    CLS_EOL  = 2'd2
  } tok_class_e;

  // Flags stored next to each character. The character itself is kept
  // outside this struct so its width can follow the DATA_WIDTH parameter.
  typedef struct packed {
    logic first;
    logic last;
    logic trunc;
  } tok_flags_t;

  localparam int unsigned TOK_FLAG_W = $bits(tok_flags_t);

  // Arguments are zero-extended characters so one helper serves any width.
  function automatic logic is_delim(input logic [31:0] c,
                                    input logic [31:0] eol,
                                    input logic [31:0] wc,
                                    input logic [31:0] wc2);
    return (c == eol) || (c == wc) || (c == wc2);
  endfunction

  function automatic tok_class_e classify(input logic [31:0] c,
                                          input logic [31:0] eol,
                                          input logic [31:0] wc,
                                          input logic [31:0] wc2);
    if (!is_delim(c, eol, wc, wc2)) return CLS_CHAR;
    if (c == eol) return CLS_EOL;
    return CLS_SEP;
  endfunction

endpackage

// File: rtl/tokenizer_fifo.sv
// tokenizer_fifo
// Single-clock circular FIFO with asynchronous (combinational) read of the
// head entry. Pointers carry one extra MSB so full and empty are told apart
// when the index bits are equal.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, wdata_i    write request and entry (ignored when full)
//   pop_i              remove the head entry (ignored when empty)
//   rdata_o            current head entry
//   full_o, empty_o    occupancy status
//   level_o            number of stored entries, 0..DEPTH
// Build macro TOKENIZER_CASEFOLD_EN has no effect in this file.
module tokenizer_fifo
  import tokenizer_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 11
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers decide what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tokenizer_stream.sv
// tokenizer_stream
// Byte-serial tokenizer between the UART receiver and the parser. Characters
// arrive over a valid/ready handshake, are split into tokens on WC/WC2/EOL and
// buffered in tokenizer_fifo; only complete tokens are offered downstream,
// framed with first/last/eol/trunc flags. EOL is also emitted as its own
// one-character token.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_en               block enable; low stalls both handshakes and holds state
//   i_data, i_valid    input character and its valid
//   o_ready            input character can be accepted
//   o_data, o_valid    head character and its valid
//   i_ready            parser accepts the head character
//   o_first, o_last    head is the first / last character of its token
//   o_eol              head is the EOL token
//   o_trunc            on the last character: token was cut at MAX_TOKEN
//   o_tokens           complete tokens currently held
// Build macro TOKENIZER_CASEFOLD_EN: when defined, ASCII a..z are stored as
// A..Z (delimiter detection still uses the raw byte).
module tokenizer_stream
  import tokenizer_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter int unsigned            DEPTH      = 64,
  parameter int unsigned            MAX_TOKEN  = 32,
  parameter logic [DATA_WIDTH-1:0]  EOL        = DATA_WIDTH'(TOK_CHAR_EOL),
  parameter logic [DATA_WIDTH-1:0]  WC         = DATA_WIDTH'(TOK_CHAR_WC),
  parameter logic [DATA_WIDTH-1:0]  WC2        = DATA_WIDTH'(TOK_CHAR_WC2)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_first,
  output logic                    o_last,
  output logic                    o_eol,
  output logic                    o_trunc,
  output logic [$clog2(DEPTH):0]  o_tokens
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned LEN_W = $clog2(MAX_TOKEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_TOKEN);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    tok_flags_t            flags;
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  entry_t           stage_q, stage_d;
  logic             stage_vld_q, stage_vld_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             eol_pend_q, eol_pend_d;
  logic [CW-1:0]    tok_cnt_q, tok_cnt_d;

  entry_t           push_entry;
  entry_t           head;
  entry_t           eol_entry;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_level;

  logic             accept;
  logic             eol_flush;
  tok_class_e       in_class;

  function automatic logic [DATA_WIDTH-1:0] fold_char(input logic [DATA_WIDTH-1:0] c);
`ifdef TOKENIZER_CASEFOLD_EN
    if ((32'(c) >= 32'(TOK_CHAR_LOWER_A)) && (32'(c) <= 32'(TOK_CHAR_LOWER_Z)))
      return c - DATA_WIDTH'(TOK_FOLD_OFFSET);
    return c;
`else
    return c;
`endif
  endfunction

  tokenizer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // The reset term makes o_ready fall the moment reset is asserted rather
  // than waiting for the registers to clear; i_valid never feeds o_ready.
  assign o_ready   = i_rst_n && i_en && !fifo_full && !eol_pend_q;
  assign accept    = o_ready && i_valid;
  assign in_class  = classify(32'(i_data), 32'(EOL), 32'(WC), 32'(WC2));

  // A pending EOL token needs one free slot; o_ready is already low while it
  // waits, so it never competes with an accepted character.
  assign eol_flush = i_en && eol_pend_q && (fifo_level < CW'(DEPTH));

  assign eol_entry = '{data: EOL, flags: '{first: 1'b1, last: 1'b1, trunc: 1'b0}};

  // Staging keeps the newest character of the open token back from the FIFO
  // so that, when a delimiter arrives, it can be written with last=1 without
  // rewriting an entry already stored.
  always_comb begin
    stage_d     = stage_q;
    stage_vld_d = stage_vld_q;
    len_d       = len_q;
    eol_pend_d  = eol_pend_q;
    fifo_push   = 1'b0;
    push_entry  = '0;
    if (eol_flush) begin
      fifo_push  = 1'b1;
      push_entry = eol_entry;
      eol_pend_d = 1'b0;
    end else if (accept) begin
      case (in_class)
        CLS_EOL: begin
          fifo_push = 1'b1;
          if (stage_vld_q) begin
            push_entry            = stage_q;
            push_entry.flags.last = 1'b1;
            stage_d               = '0;
            stage_vld_d           = 1'b0;
            len_d                 = '0;
            eol_pend_d            = 1'b1;
          end else begin
            push_entry = eol_entry;
          end
        end
        CLS_SEP: begin
          if (stage_vld_q) begin
            fifo_push             = 1'b1;
            push_entry            = stage_q;
            push_entry.flags.last = 1'b1;
            stage_d               = '0;
            stage_vld_d           = 1'b0;
            len_d                 = '0;
          end
        end
        default: begin
          if (len_q == MAX_LEN) begin
            stage_d.flags.trunc = 1'b1;
          end else begin
            if (stage_vld_q) begin
              fifo_push              = 1'b1;
              push_entry.data        = stage_q.data;
              push_entry.flags.first = stage_q.flags.first;
            end
            stage_d.data        = fold_char(i_data);
            stage_d.flags.first = !stage_vld_q;
            stage_d.flags.last  = 1'b0;
            stage_d.flags.trunc = 1'b0;
            stage_vld_d         = 1'b1;
            len_d               = len_q + LEN_W'(1);
          end
        end
      endcase
    end
  end

  // Token count follows writes and reads of last-flagged entries; both in
  // the same cycle cancel out.
  always_comb begin
    tok_cnt_d = tok_cnt_q;
    case ({fifo_push && push_entry.flags.last, fifo_pop && head.flags.last})
      2'b10:   tok_cnt_d = tok_cnt_q + CW'(1);
      2'b01:   tok_cnt_d = tok_cnt_q - CW'(1);
      default: tok_cnt_d = tok_cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      len_q       <= '0;
      eol_pend_q  <= 1'b0;
      tok_cnt_q   <= '0;
    end else begin
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      len_q       <= len_d;
      eol_pend_q  <= eol_pend_d;
      tok_cnt_q   <= tok_cnt_d;
    end
  end

  // Only complete tokens are offered; the flags are gated so stale FIFO
  // contents never show up while nothing is valid.
  assign o_valid  = i_en && (tok_cnt_q != '0) && !fifo_empty;
  assign fifo_pop = o_valid && i_ready;
  assign o_data   = head.data;
  assign o_first  = o_valid && head.flags.first;
  assign o_last   = o_valid && head.flags.last;
  assign o_eol    = o_valid && head.flags.last && (head.data == EOL);
  assign o_trunc  = o_valid && head.flags.last && head.flags.trunc;
  assign o_tokens = tok_cnt_q;

endmodule

// File: tb/tb_tokenizer_stream.sv
// tb_tokenizer_stream
// Directed bench for tokenizer_stream built with DEPTH=8, MAX_TOKEN=4.
// A string-level reference model turns each input string into the expected
// token entries; a monitor compares every popped character with it.
// Honours TOKENIZER_CASEFOLD_EN in the model the same way the design does.
module tb_tokenizer_stream;

  localparam int DEPTH = 8;
  localparam int MAXT  = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_en = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b0;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_first;
  logic       o_last;
  logic       o_eol;
  logic       o_trunc;
  logic [3:0] o_tokens;

  tokenizer_stream #(
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH),
    .MAX_TOKEN  (MAXT)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (i_en),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_first  (o_first),
    .o_last   (o_last),
    .o_eol    (o_eol),
    .o_trunc  (o_trunc),
    .o_tokens (o_tokens)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
    logic       trunc;
  } expEntry_t;

  expEntry_t  expQ[$];
  logic [7:0] curTok[$];
  bit         curTrunc = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         peakTokens = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic expEntry_t mkEntry(input logic [7:0] d, input logic f, input logic l, input logic t);
    expEntry_t e;
    e.data = d; e.first = f; e.last = l; e.trunc = t;
    return e;
  endfunction

  function automatic logic [7:0] foldModel(input logic [7:0] c);
`ifdef TOKENIZER_CASEFOLD_EN
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'd32;
`endif
    return c;
  endfunction

  function automatic int completeTokens();
    int n = 0;
    foreach (expQ[k]) if (expQ[k].last) n++;
    return n;
  endfunction

  // Close the open model token: keep at most MAXT characters, mark the
  // final kept one as last (and trunc if anything was dropped).
  function automatic void emitToken();
    int n = curTok.size();
    for (int k = 0; k < n; k++)
      expQ.push_back(mkEntry(curTok[k], k == 0, k == n - 1, (k == n - 1) && curTrunc));
    curTok.delete();
    curTrunc = 1'b0;
  endfunction

  function automatic void modelFeed(input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h0A) begin
        emitToken();
        expQ.push_back(mkEntry(8'h0A, 1'b1, 1'b1, 1'b0));
      end else if (c == 8'h20 || c == 8'h09) begin
        emitToken();
      end else if (curTok.size() < MAXT) begin
        curTok.push_back(foldModel(c));
      end else begin
        curTrunc = 1'b1;
      end
    end
  endfunction

  function automatic void modelReset();
    expQ.delete();
    curTok.delete();
    curTrunc = 1'b0;
  endfunction

  // Drive one character per cycle, holding it until o_ready is seen high
  // half a cycle before the accepting edge.
  task automatic applyStimulus(input string s);
    int waitCycles;
    for (int i = 0; i < s.len(); i++) begin
      @(negedge i_clk);
      i_data  = s[i];
      i_valid = 1'b1;
      #1;
      waitCycles = 0;
      while (!o_ready && waitCycles < 100) begin
        @(negedge i_clk);
        #1;
        waitCycles++;
      end
      checkOutput("input accepted", 32'(o_ready), 32'd1);
      @(posedge i_clk);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int c = 0; c < 200 && expQ.size() != 0; c++) @(negedge i_clk);
    checkOutput({name, " drained"}, 32'(expQ.size()), 32'd0);
    @(negedge i_clk);
    #1;
    checkOutput({name, " valid after drain"}, 32'(o_valid), 32'd0);
    checkOutput({name, " tokens after drain"}, 32'(o_tokens), 32'd0);
  endtask

  // Compare process: on every cycle out of reset, idle flags must be low and
  // every accepted output character must match the model's next entry.
  always @(negedge i_clk) begin
    expEntry_t e;
    #2;
    if (i_rst_n) begin
      if (int'(o_tokens) > peakTokens) peakTokens = int'(o_tokens);
      if (!o_valid) begin
        checkOutput("idle flags", 32'({o_first, o_last, o_eol, o_trunc}), 32'd0);
      end else begin
        checkOutput("valid needs complete token", 32'(completeTokens() > 0), 32'd1);
        if (i_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected pop: got data %0h, required no output", o_data);
          end else begin
            e = expQ.pop_front();
            checkOutput("pop data", 32'(o_data), 32'(e.data));
            checkOutput("pop first", 32'(o_first), 32'(e.first));
            checkOutput("pop last", 32'(o_last), 32'(e.last));
            checkOutput("pop trunc", 32'(o_trunc), 32'(e.trunc));
            checkOutput("pop eol", 32'(o_eol), 32'(e.last && e.data == 8'h0A));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values with the block enabled
    #3;
    checkOutput("reset o_valid", 32'(o_valid), 32'd0);
    checkOutput("reset o_ready", 32'(o_ready), 32'd0);
    checkOutput("reset flags", 32'({o_first, o_last, o_eol, o_trunc}), 32'd0);
    checkOutput("reset o_tokens", 32'(o_tokens), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Two words and a line end, parser always ready
    i_ready = 1'b1;
    peakTokens = 0;
    modelFeed("AB CD\n");
    checkOutput("model AB CD size", 32'(expQ.size()), 32'd5);
    checkOutput("model B entry", 32'(expQ[1]), 32'(mkEntry(8'h42, 1'b0, 1'b1, 1'b0)));
    checkOutput("model EOL entry", 32'(expQ[4]), 32'(mkEntry(8'h0A, 1'b1, 1'b1, 1'b0)));
    applyStimulus("AB CD\n");
    waitDrain("AB CD");
    checkOutput("AB CD peak tokens", 32'(peakTokens), 32'd2);

    // Separator runs collapse; bare EOL still forms its own token
    modelFeed("  X\t\t\n");
    checkOutput("model X size", 32'(expQ.size()), 32'd2);
    checkOutput("model X entry", 32'(expQ[0]), 32'(mkEntry(8'h58, 1'b1, 1'b1, 1'b0)));
    applyStimulus("  X\t\t\n");
    waitDrain("separators");

    // Overlong token truncated at MAX_TOKEN
    modelFeed("ABCDEFG ");
    checkOutput("model trunc size", 32'(expQ.size()), 32'd4);
    checkOutput("model D entry", 32'(expQ[3]), 32'(mkEntry(8'h44, 1'b0, 1'b1, 1'b1)));
    applyStimulus("ABCDEFG ");
    waitDrain("truncation");

    // Lower-case word: folded only when the feature is built in
    modelFeed("dup ");
`ifdef TOKENIZER_CASEFOLD_EN
    checkOutput("model fold first", 32'(expQ[0].data), 32'h44);
`else
    checkOutput("model fold first", 32'(expQ[0].data), 32'h64);
`endif
    applyStimulus("dup ");
    waitDrain("casefold");

    // Enable hold, then reset with a complete token and an open token
    i_ready = 1'b0;
    modelFeed("Z AB");
    applyStimulus("Z AB");
    repeat (2) @(negedge i_clk);
    #1;
    checkOutput("held token valid", 32'(o_valid), 32'd1);
    checkOutput("held token count", 32'(o_tokens), 32'(completeTokens()));
    @(negedge i_clk);
    i_en = 1'b0;
    #1;
    checkOutput("disabled o_valid", 32'(o_valid), 32'd0);
    checkOutput("disabled o_ready", 32'(o_ready), 32'd0);
    repeat (3) @(negedge i_clk);
    i_en = 1'b1;
    #1;
    checkOutput("re-enabled o_valid", 32'(o_valid), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("mid-token reset o_valid", 32'(o_valid), 32'd0);
    checkOutput("mid-token reset o_ready", 32'(o_ready), 32'd0);
    checkOutput("mid-token reset flags", 32'({o_first, o_last, o_eol, o_trunc}), 32'd0);
    checkOutput("mid-token reset o_tokens", 32'(o_tokens), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    modelFeed("Q ");
    checkOutput("model Q entry", 32'(expQ[0]), 32'(mkEntry(8'h51, 1'b1, 1'b1, 1'b0)));
    applyStimulus("Q ");
    waitDrain("after reset");

    // Fill the FIFO with the parser stalled, then release it
    i_ready = 1'b0;
    modelFeed("AB CD EF GH ");
    applyStimulus("AB CD EF GH ");
    repeat (2) @(negedge i_clk);
    #1;
    checkOutput("model full entries", 32'(expQ.size()), 32'd8);
    checkOutput("full o_ready", 32'(o_ready), 32'd0);
    checkOutput("full o_tokens", 32'(o_tokens), 32'(completeTokens()));
    modelFeed("IJ");
    fork
      applyStimulus("IJ");
      begin
        repeat (3) @(negedge i_clk);
        #1;
        checkOutput("stalled o_ready", 32'(o_ready), 32'd0);
        i_ready = 1'b1;
      end
    join
    waitDrain("full");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
